ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Registered instruction-decode control stage for the pipelined RISC-V core: decodes RV32I (plus optional M extension) into the ID/EX control bundle, holds it in the ID/EX register with a valid/ready handshake, detects load-use hazards and inserts bubbles, and runs the machine-interrupt entry/exit state machine (priority-encoded IRQ lines, `mret` return). Sits between the IF/ID register and the execute stage, replacing the purely combinational decoder.

## Interface
- `NUM_IRQ`, 4: number of level-sensitive interrupt lines; line 0 has the highest priority.
- `EN_M`, 0: 1 = decode the RV32M ops (funct7 0000001, opcode 0110011); 0 = they decode as illegal.
- `CW`, `$clog2(NUM_IRQ)` (minimum 1): width of `irq_cause`.
- `clk  in  1  clock, rising edge`
- `rstn  in  1  reset, asynchronous, active-low`
- `id_valid  in  1  IF/ID holds an instruction`; `id_inst  in  32  that instruction`; `id_ready  out  1  instruction consumed this cycle`
- `ex_ready  in  1  execute stage accepts the ID/EX contents`; `flush  in  1  branch/jump redirect, kill ID and ID/EX`
- `irq  in  NUM_IRQ  interrupt requests`; `mie  in  1  global interrupt enable`
- `ex_valid  out  1`; `ex_RegWrite`, `ex_MemWrite`, `ex_ALUSrc`, `ex_mem_read`, `ex_illegal  out  1 each`
- `ex_EXTOp  out  6`; `ex_ALUOp  out  5`; `ex_NPCOp  out  3`; `ex_WDSel  out  2`; `ex_DMType  out  3`
- `ex_mdu_valid  out  1`; `ex_mdu_op  out  3  funct3 of the M op`
- `ex_rd`, `ex_rs1`, `ex_rs2  out  5 each`
- `irq_take  out  1  one-cycle pulse, interrupt entered`; `irq_cause  out  CW  index of the taken line`; `in_handler  out  1`; `int_finished  out  1  one-cycle pulse, mret retired into EX`

## Operation
- Encodings are unchanged from the current decoder: EXTOp one-hot {SHAMT, I, S, B, U, J}; NPCOp 000 +4 / 001 branch / 010 jal / 100 jalr; WDSel 00 ALU / 01 MEM / 10 PC; DMType 000 w / 001 h / 010 hu / 011 b / 100 bu.
- ALUOp: add and all load/store/jal/jalr/addi 00011, sub 00100, or 01101, and 01110, xor 01100, sll 01111, srl 10000, sra 10001, slt 01010, sltu 01011, lui 00001, auipc 00010, beq 00100, bne 00101, blt 00110, bge 00111, bltu 01000, bgeu 01001. Immediate forms use the same code as their register forms.
- M ops: ALUOp 00000, ex_mdu_valid=1, RegWrite=1, WDSel 00.
- `mret` is exactly 0x30200073. It has no write enables and NPCOp 000; the CSR block redirects the PC.
- Illegal means any encoding not listed, including mret while in RUN. It loads with ex_valid=1, ex_illegal=1, and RegWrite, MemWrite and mem_read all 0.
- rs1 is "used" by R, I, load, S, B and jalr. rs2 is "used" by R, S and B.
- Hazard = ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd matches a used rs1/rs2 of id_inst).
- FSM states: RUN, HANDLER. `in_handler` = (state==HANDLER).
  - RUN→HANDLER on an interrupt take.
  - HANDLER→RUN when mret is loaded into ID/EX.
  - IRQs are ignored in HANDLER (no nesting).
- Each cycle, highest priority first:
  - flush: ex_valid←0, id_ready=1 (the ID instruction is discarded), no take.
  - !ex_ready: hold all registers, id_ready=0.
  - take: condition is state RUN, mie, |irq, id_valid. Sets id_ready=1 and drops the instruction (its PC is the return address, captured by the CSR block), ex_valid←0, irq_take←1, irq_cause←lowest set index, state←HANDLER.
  - hazard: ex_valid←0 (bubble), id_ready=0.
  - id_valid: load the decoded bundle, ex_valid←1, id_ready=1. If the instruction is mret in HANDLER, also int_finished←1 and state←RUN.
  - otherwise ex_valid←0.
- `irq_take` and `int_finished` are 0 in every cycle not named above.
- While ex_ready=0 the two pulses still clear after one cycle.

## Timing
- Reset: every output register is 0, state is RUN, ex_valid=0. id_ready is 0 during reset.
- Latency: ID/EX outputs update on the rising edge after acceptance. They are pure register outputs, with no combinational path from id_inst.
- `id_ready` is combinational from id_valid, id_inst, ex_ready, flush, irq, mie and the registered state.
- Load-use stall: exactly one bubble. The following cycle the load has left ID/EX, the hazard deasserts and the instruction loads.
- Simultaneous flush and take: flush wins. The IRQ stays pending and is taken later.
- Simultaneous hazard and take: take wins, because the dropped instruction is re-fetched after mret.
- Reset asserted mid-handler returns to RUN immediately and asynchronously.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with id_valid=1 and ex_ready=1. Next cycle: ex_valid=1, ALUOp 00011, RegWrite=1, ex_rd=3, EXTOp 000000.
- Load-use: lw x5,0(x1) then add x6,x5,x2. Second instruction: id_ready=0 for one cycle with one ex_valid=0 bubble, then ex_rs1=5 is loaded. Repeat with rd=x0: no bubble.
- Backpressure: ex_ready=0 for 3 cycles with sltiu in ID/EX. The bundle holds ALUOp 01011 and id_ready=0 throughout.
- IRQ: mie=1, irq=4'b0110 while ori is in ID. id_ready=1, next cycle irq_take=1, irq_cause=1, in_handler=1, ex_valid=0. Raise irq[0] while in handler: no take.
- mret 0x30200073 in HANDLER: int_finished=1 for one cycle, in_handler=0. The same word in RUN gives ex_illegal=1.
- EN_M=0 vs 1 with mul 0x02208033: ex_illegal=1 vs ex_mdu_valid=1 and mdu_op 000. Flush in the same cycle as an irq: ex_valid=0, no irq_take.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Registered ID stage: RV32I(+M) decode into the ID/EX control bundle, load-use
// bubble insertion, and the machine-interrupt entry/exit state machine.
module ctrl_pipe #(
    parameter int NUM_IRQ = 4,
    parameter int EN_M    = 0,
    parameter int CW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               id_valid,
    input  logic [31:0]        id_inst,
    output logic               id_ready,
    input  logic               ex_ready,
    input  logic               flush,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mie,
    output logic               ex_valid,
    output logic               ex_RegWrite,
    output logic               ex_MemWrite,
    output logic               ex_ALUSrc,
    output logic               ex_mem_read,
    output logic               ex_illegal,
    output logic [5:0]         ex_EXTOp,
    output logic [4:0]         ex_ALUOp,
    output logic [2:0]         ex_NPCOp,
    output logic [1:0]         ex_WDSel,
    output logic [2:0]         ex_DMType,
    output logic               ex_mdu_valid,
    output logic [2:0]         ex_mdu_op,
    output logic [4:0]         ex_rd,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic               irq_take,
    output logic [CW-1:0]      irq_cause,
    output logic               in_handler,
    output logic               int_finished
);

    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       mem_read;
        logic       illegal;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
        logic       mdu_valid;
        logic [2:0] mdu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } bundle_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // EXTOp one-hot {SHAMT, I, S, B, U, J}
    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    state_t        state_q, state_d;
    logic          ex_valid_q, ex_valid_d;
    bundle_t       bun_q, bun_d;
    logic          irq_take_q, irq_take_d;
    logic [CW-1:0] irq_cause_q, irq_cause_d;
    logic          int_finished_q, int_finished_d;

    bundle_t       dec;
    logic          legal, use_rs1, use_rs2, is_mret, hazard, take;
    logic [CW-1:0] irq_idx;
    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [6:0]    f7;

    assign opcode  = id_inst[6:0];
    assign f3      = id_inst[14:12];
    assign f7      = id_inst[31:25];
    assign is_mret = (id_inst == 32'h3020_0073);

    always_comb begin
        dec     = '0;
        dec.rd  = id_inst[11:7];
        dec.rs1 = id_inst[19:15];
        dec.rs2 = id_inst[24:20];
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                dec.ext_op = EXT_U; dec.alu_op = 5'b00001;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                dec.ext_op = EXT_U; dec.alu_op = 5'b00010;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1; dec.ext_op = EXT_J; dec.alu_op = 5'b00011;
                dec.npc_op = 3'b010; dec.wd_sel = 2'b10;
            end
            OP_JALR: begin
                use_rs1 = 1'b1;
                legal = (f3 == 3'b000);
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
                dec.alu_op = 5'b00011; dec.npc_op = 3'b100; dec.wd_sel = 2'b10;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.ext_op = EXT_B; dec.npc_op = 3'b001;
                case (f3)
                    3'b000:  dec.alu_op = 5'b00100;
                    3'b001:  dec.alu_op = 5'b00101;
                    3'b100:  dec.alu_op = 5'b00110;
                    3'b101:  dec.alu_op = 5'b00111;
                    3'b110:  dec.alu_op = 5'b01000;
                    3'b111:  dec.alu_op = 5'b01001;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                use_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                dec.ext_op = EXT_I; dec.alu_op = 5'b00011; dec.wd_sel = 2'b01;
                case (f3)
                    3'b000:  dec.dm_type = 3'b011;
                    3'b001:  dec.dm_type = 3'b001;
                    3'b010:  dec.dm_type = 3'b000;
                    3'b100:  dec.dm_type = 3'b100;
                    3'b101:  dec.dm_type = 3'b010;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.mem_write = 1'b1; dec.alu_src = 1'b1;
                dec.ext_op = EXT_S; dec.alu_op = 5'b00011;
                case (f3)
                    3'b000:  dec.dm_type = 3'b011;
                    3'b001:  dec.dm_type = 3'b001;
                    3'b010:  dec.dm_type = 3'b000;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                use_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
                case (f3)
                    3'b000: dec.alu_op = 5'b00011;
                    3'b010: dec.alu_op = 5'b01010;
                    3'b011: dec.alu_op = 5'b01011;
                    3'b100: dec.alu_op = 5'b01100;
                    3'b110: dec.alu_op = 5'b01101;
                    3'b111: dec.alu_op = 5'b01110;
                    3'b001: begin
                        dec.ext_op = EXT_SHAMT; dec.alu_op = 5'b01111;
                        legal = (f7 == 7'b0000000);
                    end
                    default: begin
                        dec.ext_op = EXT_SHAMT;
                        if (f7 == 7'b0000000)      dec.alu_op = 5'b10000;
                        else if (f7 == 7'b0100000) dec.alu_op = 5'b10001;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OP_REG: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.alu_op = 5'b00011;
                        3'b001:  dec.alu_op = 5'b01111;
                        3'b010:  dec.alu_op = 5'b01010;
                        3'b011:  dec.alu_op = 5'b01011;
                        3'b100:  dec.alu_op = 5'b01100;
                        3'b101:  dec.alu_op = 5'b10000;
                        3'b110:  dec.alu_op = 5'b01101;
                        default: dec.alu_op = 5'b01110;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.alu_op = 5'b00100;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.alu_op = 5'b10001;
                end else if (f7 == 7'b0000001 && EN_M != 0) begin
                    dec.mdu_valid = 1'b1; dec.mdu_op = f3;
                end else begin
                    legal = 1'b0;
                end
            end
            // mret is only meaningful as the handler's exit; in RUN it traps as illegal
            OP_SYSTEM: legal = is_mret && (state_q == HANDLER);
            default:   legal = 1'b0;
        endcase
        if (!legal) begin
            dec.reg_write = 1'b0; dec.mem_write = 1'b0; dec.alu_src = 1'b0;
            dec.mem_read = 1'b0; dec.ext_op = '0; dec.alu_op = '0;
            dec.npc_op = '0; dec.wd_sel = '0; dec.dm_type = '0;
            dec.mdu_valid = 1'b0; dec.mdu_op = '0; dec.illegal = 1'b1;
        end
    end

    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_idx = CW'(i);
        end
    end

    assign hazard = id_valid && ex_valid_q && bun_q.mem_read && (bun_q.rd != 5'd0) &&
                    ((use_rs1 && bun_q.rd == id_inst[19:15]) ||
                     (use_rs2 && bun_q.rd == id_inst[24:20]));
    assign take   = (state_q == RUN) && mie && (|irq) && id_valid;

    always_comb begin
        state_d        = state_q;
        ex_valid_d     = ex_valid_q;
        bun_d          = bun_q;
        irq_take_d     = 1'b0;
        irq_cause_d    = irq_cause_q;
        int_finished_d = 1'b0;
        id_ready       = 1'b0;
        if (!rstn) begin
            id_ready = 1'b0;
        end else if (flush) begin
            ex_valid_d = 1'b0;
            id_ready   = 1'b1;
        end else if (!ex_ready) begin
            id_ready = 1'b0;
        end else if (take) begin
            // the dropped instruction is re-fetched after mret
            id_ready    = 1'b1;
            ex_valid_d  = 1'b0;
            irq_take_d  = 1'b1;
            irq_cause_d = irq_idx;
            state_d     = HANDLER;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
        end else if (id_valid) begin
            id_ready   = 1'b1;
            ex_valid_d = 1'b1;
            bun_d      = dec;
            if (is_mret && state_q == HANDLER) begin
                int_finished_d = 1'b1;
                state_d        = RUN;
            end
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= RUN;
            ex_valid_q     <= 1'b0;
            bun_q          <= '0;
            irq_take_q     <= 1'b0;
            irq_cause_q    <= '0;
            int_finished_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ex_valid_q     <= ex_valid_d;
            bun_q          <= bun_d;
            irq_take_q     <= irq_take_d;
            irq_cause_q    <= irq_cause_d;
            int_finished_q <= int_finished_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_RegWrite  = bun_q.reg_write;
    assign ex_MemWrite  = bun_q.mem_write;
    assign ex_ALUSrc    = bun_q.alu_src;
    assign ex_mem_read  = bun_q.mem_read;
    assign ex_illegal   = bun_q.illegal;
    assign ex_EXTOp     = bun_q.ext_op;
    assign ex_ALUOp     = bun_q.alu_op;
    assign ex_NPCOp     = bun_q.npc_op;
    assign ex_WDSel     = bun_q.wd_sel;
    assign ex_DMType    = bun_q.dm_type;
    assign ex_mdu_valid = bun_q.mdu_valid;
    assign ex_mdu_op    = bun_q.mdu_op;
    assign ex_rd        = bun_q.rd;
    assign ex_rs1       = bun_q.rs1;
    assign ex_rs2       = bun_q.rs2;
    assign irq_take     = irq_take_q;
    assign irq_cause    = irq_cause_q;
    assign in_handler   = (state_q == HANDLER);
    assign int_finished = int_finished_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed scoreboard bench for ctrl_pipe: decode, load-use bubble, backpressure,
// interrupt entry/exit and the EN_M option (second instance with EN_M=1).
module tb_ctrl_pipe;

    logic        clk, rstn, id_valid, ex_ready, flush, mie;
    logic [31:0] id_inst;
    logic [3:0]  irq;

    logic       id_ready, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_mem_read, ex_illegal;
    logic [5:0] ex_EXTOp;
    logic [4:0] ex_ALUOp;
    logic [2:0] ex_NPCOp, ex_DMType, ex_mdu_op;
    logic [1:0] ex_WDSel, irq_cause;
    logic       ex_mdu_valid, irq_take, in_handler, int_finished;
    logic [4:0] ex_rd, ex_rs1, ex_rs2;

    logic       m_id_ready, m_ex_valid, m_RegWrite, m_MemWrite, m_ALUSrc, m_mem_read, m_illegal;
    logic [5:0] m_EXTOp;
    logic [4:0] m_ALUOp;
    logic [2:0] m_NPCOp, m_DMType, m_mdu_op;
    logic [1:0] m_WDSel, m_irq_cause;
    logic       m_mdu_valid, m_irq_take, m_in_handler, m_int_finished;
    logic [4:0] m_rd, m_rs1, m_rs2;

    ctrl_pipe #(.NUM_IRQ(4), .EN_M(0)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
        .ex_ready(ex_ready), .flush(flush), .irq(irq), .mie(mie),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_mem_read(ex_mem_read), .ex_illegal(ex_illegal),
        .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
        .ex_DMType(ex_DMType), .ex_mdu_valid(ex_mdu_valid), .ex_mdu_op(ex_mdu_op),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .irq_take(irq_take),
        .irq_cause(irq_cause), .in_handler(in_handler), .int_finished(int_finished)
    );

    ctrl_pipe #(.NUM_IRQ(4), .EN_M(1)) u_m (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_inst(id_inst), .id_ready(m_id_ready),
        .ex_ready(ex_ready), .flush(flush), .irq(irq), .mie(mie),
        .ex_valid(m_ex_valid), .ex_RegWrite(m_RegWrite), .ex_MemWrite(m_MemWrite),
        .ex_ALUSrc(m_ALUSrc), .ex_mem_read(m_mem_read), .ex_illegal(m_illegal),
        .ex_EXTOp(m_EXTOp), .ex_ALUOp(m_ALUOp), .ex_NPCOp(m_NPCOp), .ex_WDSel(m_WDSel),
        .ex_DMType(m_DMType), .ex_mdu_valid(m_mdu_valid), .ex_mdu_op(m_mdu_op),
        .ex_rd(m_rd), .ex_rs1(m_rs1), .ex_rs2(m_rs2), .irq_take(m_irq_take),
        .irq_cause(m_irq_cause), .in_handler(m_in_handler), .int_finished(m_int_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid, full;
        logic [4:0] alu;
        logic [5:0] ext;
        logic       rw, mr, ill, mdv;
        logic [2:0] mdop;
        logic [4:0] rd, rs1, rs2;
        logic       take;
        logic [1:0] cause;
        logic       inh, fin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADD3  = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] I_LW0   = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] I_ADD60 = 32'h0020_0333; // add x6,x0,x2
    localparam logic [31:0] I_SLTIU = 32'h0050_B393; // sltiu x7,x1,5
    localparam logic [31:0] I_ORI   = 32'h0010_E413; // ori x8,x1,1
    localparam logic [31:0] I_MRET  = 32'h3020_0073;
    localparam logic [31:0] I_MUL   = 32'h0220_8033; // mul x0,x1,x2

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t bub(input logic take, input logic [1:0] cause, input logic inh);
        exp_t e = '{default: '0};
        e.take = take; e.cause = cause; e.inh = inh;
        return e;
    endfunction

    function automatic exp_t ins(input logic [4:0] alu, input logic [5:0] ext, input logic rw,
                                 input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic inh);
        exp_t e = '{default: '0};
        e.valid = 1'b1; e.full = 1'b1; e.alu = alu; e.ext = ext; e.rw = rw; e.mr = mr;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.inh = inh;
        return e;
    endfunction

    function automatic exp_t part(input logic ill, input logic inh, input logic fin);
        exp_t e = '{default: '0};
        e.valid = 1'b1; e.ill = ill; e.inh = inh; e.fin = fin;
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
            return;
        end
        checks--;
        e = sb.pop_front();
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(e.valid));
        chk({tag, ".irq_take"}, 32'(irq_take), 32'(e.take));
        chk({tag, ".in_handler"}, 32'(in_handler), 32'(e.inh));
        chk({tag, ".int_finished"}, 32'(int_finished), 32'(e.fin));
        if (e.take) chk({tag, ".irq_cause"}, 32'(irq_cause), 32'(e.cause));
        if (e.valid) begin
            chk({tag, ".RegWrite"}, 32'(ex_RegWrite), 32'(e.rw));
            chk({tag, ".mem_read"}, 32'(ex_mem_read), 32'(e.mr));
            chk({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
            chk({tag, ".mdu_valid"}, 32'(ex_mdu_valid), 32'(e.mdv));
            if (e.ill) chk({tag, ".MemWrite"}, 32'(ex_MemWrite), 32'd0);
            if (e.full) begin
                chk({tag, ".ALUOp"}, 32'(ex_ALUOp), 32'(e.alu));
                chk({tag, ".EXTOp"}, 32'(ex_EXTOp), 32'(e.ext));
                chk({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
                chk({tag, ".rs1"}, 32'(ex_rs1), 32'(e.rs1));
                chk({tag, ".rs2"}, 32'(ex_rs2), 32'(e.rs2));
            end
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] inst,
                        input logic er, input logic fl, input logic [3:0] ir, input logic m,
                        input logic rdy_exp, input exp_t e);
        id_valid = v; id_inst = inst; ex_ready = er; flush = fl; irq = ir; mie = m;
        #1;
        chk({tag, ".id_ready"}, 32'(id_ready), 32'(rdy_exp));
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        rstn = 1'b0;
        id_valid = 1'b1; id_inst = I_ADD3; ex_ready = 1'b1; flush = 1'b0; irq = 4'b0001; mie = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.id_ready", 32'(id_ready), 32'd0);
        chk("rst.ex_valid", 32'(ex_valid), 32'd0);
        chk("rst.in_handler", 32'(in_handler), 32'd0);
        chk("rst.irq_take", 32'(irq_take), 32'd0);
        chk("rst.ALUOp", 32'(ex_ALUOp), 32'd0);
        id_valid = 1'b0; irq = 4'b0000; mie = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // basic decode and load-use
        step("add", 1, I_ADD3, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b000000, 1, 0, 3, 1, 2, 0));
        step("lw5", 1, I_LW5, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b010000, 1, 1, 5, 1, 0, 0));
        step("lu_stall", 1, I_ADD6, 1, 0, 4'b0000, 0, 0, bub(0, 2'd0, 0));
        step("lu_go", 1, I_ADD6, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b000000, 1, 0, 6, 5, 2, 0));
        step("lw0", 1, I_LW0, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b010000, 1, 1, 0, 1, 0, 0));
        step("x0_nobub", 1, I_ADD60, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b000000, 1, 0, 6, 0, 2, 0));

        // backpressure
        step("sltiu", 1, I_SLTIU, 1, 0, 4'b0000, 0, 1, ins(5'b01011, 6'b010000, 1, 0, 7, 1, 5, 0));
        for (int k = 0; k < 3; k++)
            step("bp_hold", 1, I_ADD3, 0, 0, 4'b0000, 0, 0, ins(5'b01011, 6'b010000, 1, 0, 7, 1, 5, 0));
        step("bp_release", 1, I_ADD3, 1, 0, 4'b0000, 0, 1, ins(5'b00011, 6'b000000, 1, 0, 3, 1, 2, 0));

        // interrupt entry, no nesting, mret exit, mret in RUN
        step("irq_take", 1, I_ORI, 1, 0, 4'b0110, 1, 1, bub(1, 2'd1, 1));
        step("irq_nonest", 1, I_ORI, 1, 0, 4'b0001, 1, 1, ins(5'b01101, 6'b010000, 1, 0, 8, 1, 1, 1));
        step("mret_exit", 1, I_MRET, 1, 0, 4'b0000, 1, 1, part(0, 0, 1));
        step("mret_run", 1, I_MRET, 1, 0, 4'b0000, 1, 1, part(1, 0, 0));

        // M extension disabled vs enabled
        step("mul_nom", 1, I_MUL, 1, 0, 4'b0000, 1, 1, part(1, 0, 0));
        chk("mul_m.mdu_valid", 32'(m_mdu_valid), 32'd1);
        chk("mul_m.mdu_op", 32'(m_mdu_op), 32'd0);
        chk("mul_m.illegal", 32'(m_illegal), 32'd0);
        chk("mul_m.RegWrite", 32'(m_RegWrite), 32'd1);
        chk("mul_m.ALUOp", 32'(m_ALUOp), 32'd0);
        chk("mul_m.WDSel", 32'(m_WDSel), 32'd0);

        // flush beats take; irq stays pending and is taken next
        step("flush_irq", 1, I_ADD3, 1, 1, 4'b0001, 1, 1, bub(0, 2'd0, 0));
        step("irq_pending", 1, I_ADD3, 1, 0, 4'b0001, 1, 1, bub(1, 2'd0, 1));
        step("pulse_clear", 0, I_ADD3, 1, 0, 4'b0000, 1, 0, bub(0, 2'd0, 1));
        step("mret_exit2", 1, I_MRET, 1, 0, 4'b0000, 1, 1, part(0, 0, 1));

        // take beats hazard; pulse clears under backpressure
        step("lw5b", 1, I_LW5, 1, 0, 4'b0000, 1, 1, ins(5'b00011, 6'b010000, 1, 1, 5, 1, 0, 0));
        step("take_vs_haz", 1, I_ADD6, 1, 0, 4'b0100, 1, 1, bub(1, 2'd2, 1));
        step("pulse_bp", 0, I_ADD6, 0, 0, 4'b0000, 1, 0, bub(0, 2'd0, 1));

        // asynchronous reset in the handler
        rstn = 1'b0;
        #1;
        chk("async_rst.in_handler", 32'(in_handler), 32'd0);
        chk("async_rst.ex_valid", 32'(ex_valid), 32'd0);
        chk("async_rst.id_ready", 32'(id_ready), 32'd0);
        chk("async_rst.sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
